dds_sweep_controller: RTL and testbench

//  Sequences the DDS tuning word to perform linear frequency sweeps without host traffic.

---
 rtl/dds_sweep_controller.sv | 115 +++++++++++
 tb/tb_dds_sweep_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_controller.sv
// Linear DDS frequency sweep sequencer: steps the tuning word from f_start by
// +/-f_step, holding each point for max(dwell,1) cycles, optionally looping.
module dds_sweep_controller #(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   f_start,
    input  logic [WIDTH-1:0]   f_step,
    input  logic               down,
    input  logic [CNT_W-1:0]   n_points,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               loop,
    output logic [WIDTH-1:0]   m,
    output logic               set,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   step_idx
);

    typedef enum logic {IDLE, DWELL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0]   f_start;
        logic [WIDTH-1:0]   f_step;
        logic               down;
        logic [CNT_W-1:0]   last_idx;
        logic [DWELL_W-1:0] reload;
        logic               loop;
    } cfg_t;

    state_t             state;
    cfg_t               cfg;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_m1;

    // dwell of 0 behaves as 1, so the reload value saturates at 0
    assign dwell_m1 = (dwell == '0) ? '0 : dwell - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cfg      <= '0;
            cnt      <= '0;
            m        <= '0;
            set      <= 1'b0;
            en       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_idx <= '0;
        end else begin
            set  <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                // m is left on the last point so the DDS output does not jump
                state    <= IDLE;
                cnt      <= '0;
                en       <= 1'b0;
                busy     <= 1'b0;
                step_idx <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (n_points == '0) begin
                                done <= 1'b1;
                            end else begin
                                cfg.f_start  <= f_start;
                                cfg.f_step   <= f_step;
                                cfg.down     <= down;
                                cfg.last_idx <= n_points - 1'b1;
                                cfg.reload   <= dwell_m1;
                                cfg.loop     <= loop;
                                m            <= f_start;
                                set          <= 1'b1;
                                en           <= 1'b1;
                                busy         <= 1'b1;
                                step_idx     <= '0;
                                cnt          <= dwell_m1;
                                state        <= DWELL;
                            end
                        end
                    end
                    DWELL: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (step_idx != cfg.last_idx) begin
                            m        <= cfg.down ? m - cfg.f_step : m + cfg.f_step;
                            step_idx <= step_idx + 1'b1;
                            set      <= 1'b1;
                            cnt      <= cfg.reload;
                        end else if (cfg.loop) begin
                            m        <= cfg.f_start;
                            step_idx <= '0;
                            set      <= 1'b1;
                            cnt      <= cfg.reload;
                        end else begin
                            en    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Bench for dds_sweep_controller: directed spec scenarios plus randomized
// traffic, all checked every cycle against a closed-form sweep model.
module tb_dds_sweep_controller;
    localparam int W = 32, C = 16, DW = 24;

    logic          clk = 1'b0;
    logic          rst, start, abort, down, loop;
    logic [W-1:0]  f_start, f_step;
    logic [C-1:0]  n_points;
    logic [DW-1:0] dwell;
    logic [W-1:0]  m;
    logic          set, en, busy, done;
    logic [C-1:0]  step_idx;

    dds_sweep_controller #(.WIDTH(W), .CNT_W(C), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .down(down), .n_points(n_points),
        .dwell(dwell), .loop(loop), .m(m), .set(set), .en(en), .busy(busy),
        .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a sweep is "cycle j since start"; the point on m is (j / D) mod n
    // and its value is f_start +/- k*f_step.
    bit          act;
    longint      j;
    logic [W-1:0] c_fs, c_st;
    bit          c_dn, c_lp;
    int          c_n, c_d;
    logic [W-1:0] e_m;
    bit          e_set, e_en, e_busy, e_done, idx_known;
    int          e_idx;
    logic [W-1:0] setq[$];

    function automatic void model_point();
        int k;
        k      = int'((j / c_d) % c_n);
        e_m    = c_dn ? c_fs - W'(k) * c_st : c_fs + W'(k) * c_st;
        e_set  = (j % c_d) == 0;
        e_en   = 1; e_busy = 1; e_done = 0;
        e_idx  = k; idx_known = 1;
    endfunction

    function automatic void model_edge();
        if (rst) begin
            act = 0; e_m = '0; e_set = 0; e_en = 0; e_busy = 0; e_done = 0;
            e_idx = 0; idx_known = 1;
        end else if (abort) begin
            act = 0; e_set = 0; e_en = 0; e_busy = 0; e_done = 0;
            e_idx = 0; idx_known = 1;
        end else if (!act) begin
            e_set = 0; e_done = 0;
            if (start) begin
                if (n_points == 0) e_done = 1;
                else begin
                    act = 1; j = 0;
                    c_fs = f_start; c_st = f_step; c_dn = down; c_lp = loop;
                    c_n = int'(n_points); c_d = (dwell == 0) ? 1 : int'(dwell);
                    model_point();
                end
            end
        end else begin
            j++;
            if (!c_lp && j == longint'(c_n) * c_d) begin
                act = 0; e_set = 0; e_en = 0; e_busy = 0; e_done = 1;
                idx_known = 0;
            end else model_point();
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("m", m, e_m);
        chk("set", set, e_set);
        chk("en", en, e_en);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (idx_known) chk("step_idx", step_idx, e_idx);
        if (set) setq.push_back(m);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input logic [W-1:0] fs, input logic [W-1:0] st, input bit dn,
                       input int n, input int d, input bit lp);
        f_start = fs; f_step = st; down = dn; n_points = C'(n); dwell = DW'(d); loop = lp;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0;
        cfg(0, 0, 0, 0, 0, 0);
        ticks(2);
        chk("rst_m", m, 0);
        chk("rst_busy", busy, 0);
        rst = 0; tick();

        // 1) basic up-sweep
        cfg(1000, 250, 0, 4, 3, 0);
        setq.delete();
        pulse_start();
        ticks(14);
        chk("t1_npts", setq.size(), 4);
        if (setq.size() == 4) begin
            chk("t1_p0", setq[0], 1000); chk("t1_p1", setq[1], 1250);
            chk("t1_p2", setq[2], 1500); chk("t1_p3", setq[3], 1750);
        end

        // 2) wrap-around, dwell 1
        cfg(32'hFFFF_FF00, 32'h200, 0, 2, 1, 0);
        setq.delete();
        pulse_start(); ticks(4);
        chk("t2_npts", setq.size(), 2);
        if (setq.size() == 2) chk("t2_wrap", setq[1], 32'h0000_0100);

        // 3) down-sweep, dwell 0, loop
        cfg(500, 100, 1, 3, 0, 1);
        setq.delete();
        pulse_start(); ticks(8);
        chk("t3_npts", setq.size(), 9);
        if (setq.size() >= 4) chk("t3_loop", setq[3], 500);
        abort = 1; tick(); abort = 0; tick();

        // 4) abort mid-sweep
        cfg(1000, 250, 0, 4, 3, 0);
        pulse_start(); ticks(4);
        abort = 1; tick(); abort = 0;
        chk("t4_hold", m, 1250);
        chk("t4_en", en, 0);
        ticks(4);

        // 5) zero points, restart while busy, start+abort
        cfg(77, 1, 0, 0, 2, 0);
        pulse_start();
        chk("t5_done", done, 1);
        ticks(2);
        cfg(1000, 250, 0, 4, 3, 0);
        pulse_start(); ticks(3);
        cfg(5, 5, 1, 2, 1, 1);
        pulse_start(); ticks(10);
        start = 1; abort = 1; tick(); start = 0; abort = 0;
        chk("t5_sa_busy", busy, 0);
        tick();

        // 6) reset mid-sweep, then a normal sweep
        cfg(1000, 250, 0, 4, 3, 0);
        pulse_start(); ticks(7);
        rst = 1; tick(); rst = 0;
        chk("t6_m", m, 0);
        pulse_start(); ticks(14);

        // randomized traffic; config wiggles every cycle to exercise latching
        for (int i = 0; i < 4000; i++) begin
            f_start  = $urandom;
            f_step   = ($urandom_range(0, 1) != 0) ? $urandom : W'($urandom_range(0, 300));
            down     = 1'($urandom_range(0, 1));
            n_points = C'($urandom_range(0, 5));
            dwell    = DW'($urandom_range(0, 4));
            loop     = ($urandom_range(0, 3) == 0);
            start    = ($urandom_range(0, 5) == 0);
            abort    = ($urandom_range(0, 59) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        start = 0; abort = 0; rst = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
